// File: rtl/pwm_regs_pkg.sv
// Shared definitions for the PWM peripheral register map and the ramp
// sequencer: register addresses, control-register bit positions, the
// control encodings the sequencer writes, and the sequencer state type.
package pwm_regs_pkg;

  localparam int DATA_W = 16;

  // Slave register addresses of the PWM peripheral
  localparam logic [DATA_W-1:0] REG_CTRL = 16'd0;
  localparam logic [DATA_W-1:0] REG_DIV  = 16'd2;
  localparam logic [DATA_W-1:0] REG_PER  = 16'd4;
  localparam logic [DATA_W-1:0] REG_DC   = 16'd6;

  // Control register bit positions
  localparam int CTRL_EXTCLK = 0;
  localparam int CTRL_PWM    = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_CONT   = 3;
  localparam int CTRL_OE     = 4;
  localparam int CTRL_INT    = 5;
  localparam int CTRL_EXTDC  = 6;
  localparam int CTRL_RST    = 7;

  // Control encodings: counter reset, run (PWM mode + start + output on,
  // reset bit clear), and fully off.
  localparam logic [DATA_W-1:0] CTRL_RESET = DATA_W'(1) << CTRL_RST;
  localparam logic [DATA_W-1:0] CTRL_RUN   = (DATA_W'(1) << CTRL_PWM) |
                                             (DATA_W'(1) << CTRL_START) |
                                             (DATA_W'(1) << CTRL_OE);
  localparam logic [DATA_W-1:0] CTRL_OFF   = '0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_RST,
    S_W_DIV,
    S_W_PER,
    S_W_DC,
    S_W_EN,
    S_HOLD,
    S_FIN,
    S_W_STOP
  } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Wishbone write bus between the ramp sequencer (master) and one PWM
// peripheral (slave).
//   cyc, stb, we : cycle / strobe / write enable from the master
//   adr, data    : register address and write data from the master
//   ack          : acknowledge from the slave
interface pwm_ramp_ctrl_if;
  import pwm_regs_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [DATA_W-1:0] adr;
  logic [DATA_W-1:0] data;
  logic              ack;

  modport master (output cyc, output stb, output we, output adr, output data, input ack);
  modport slave  (input cyc, input stb, input we, input adr, input data, output ack);

endinterface

// File: rtl/wb_single_write.sv
// Single-beat Wishbone write master with acknowledge timeout.
//   clk, rst_n        : clock, asynchronous active-low reset
//   go                : start a write (accepted only when idle)
//   adr_in, data_in   : address/data captured on go
//   ack               : slave acknowledge
//   cyc, stb, we      : bus control, high for the whole write
//   adr, data         : held stable for the whole write
//   busy              : a write is in flight
//   done              : ack seen this cycle; the write ends at this edge
//   timeout           : last allowed cycle passed without ack; write ends
module wb_single_write
  import pwm_regs_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [DATA_W-1:0] adr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ack,
  output logic              cyc,
  output logic              stb,
  output logic              we,
  output logic [DATA_W-1:0] adr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  logic          act;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act  <= 1'b0;
      cnt  <= '0;
      adr  <= '0;
      data <= '0;
    end else if (!act) begin
      if (go) begin
        act  <= 1'b1;
        cnt  <= '0;
        adr  <= adr_in;
        data <= data_in;
      end
    end else if (ack || (cnt == LAST)) begin
      act <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cyc     = act;
  assign stb     = act;
  assign we      = act;
  assign busy    = act;
  assign done    = act & ack;
  // cnt == LAST marks the ACK_TIMEOUT-th strobe cycle
  assign timeout = act & ~ack & (cnt == LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Wishbone master that programs one PWM peripheral and ramps its duty cycle.
//   i_wb_clk, i_wb_rst_n : clock, asynchronous active-low reset
//   i_start, i_stop      : sequence start / abort pulses (stop wins)
//   i_divisor, i_period  : values written to the divisor / period registers
//   i_dc_start, i_dc_end : first and final duty cycle
//   i_dc_step, i_hold    : step magnitude, clocks held per step (0 acts as 1)
//   wb                   : master side of the PWM register bus
//   o_busy, o_done       : sequence active / ramp finished pulse
//   o_err                : sticky ack timeout, cleared by an accepted start
//   o_dc_cur             : duty cycle most recently acknowledged
module pwm_ramp_ctrl
  import pwm_regs_pkg::*;
#(
  parameter logic [DATA_W-1:0] ADR_CTRL    = REG_CTRL,
  parameter logic [DATA_W-1:0] ADR_DIV     = REG_DIV,
  parameter logic [DATA_W-1:0] ADR_PER     = REG_PER,
  parameter logic [DATA_W-1:0] ADR_DC      = REG_DC,
  parameter int                ACK_TIMEOUT = 16
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_divisor,
  input  logic [DATA_W-1:0] i_period,
  input  logic [DATA_W-1:0] i_dc_start,
  input  logic [DATA_W-1:0] i_dc_end,
  input  logic [DATA_W-1:0] i_dc_step,
  input  logic [DATA_W-1:0] i_hold,
  pwm_ramp_ctrl_if.master   wb,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_dc_cur
);

  ramp_state_e state_q, state_d;

  logic [DATA_W-1:0] div_q, per_q, end_q, step_q, hmax_q, dc_wr_q, hold_cnt_q;
  logic              up_q, running_q, stop_pend_q, err_q;
  logic [DATA_W-1:0] dc_cur_q;

  logic              wr_go, wr_busy, wr_done, wr_timeout;
  logic [DATA_W-1:0] wr_adr, wr_data;
  logic              accept_start, stop_now, is_write;

  // Next ramp value computed one bit wide so carry/borrow is visible;
  // passing the target or wrapping clamps to the target.
  function automatic logic [DATA_W-1:0] next_dc(input logic [DATA_W-1:0] cur,
                                                input logic [DATA_W-1:0] step,
                                                input logic [DATA_W-1:0] tgt,
                                                input logic              up);
    logic [DATA_W:0] s;
    if (up) begin
      s = {1'b0, cur} + {1'b0, step};
      if (s[DATA_W] || (s[DATA_W-1:0] > tgt)) return tgt;
    end else begin
      s = {1'b0, cur} - {1'b0, step};
      if (s[DATA_W] || (s[DATA_W-1:0] < tgt)) return tgt;
    end
    return s[DATA_W-1:0];
  endfunction

  function automatic ramp_state_e seq_next(input ramp_state_e s, input logic running);
    case (s)
      S_W_RST: return S_W_DIV;
      S_W_DIV: return S_W_PER;
      S_W_PER: return S_W_DC;
      S_W_DC:  return running ? S_HOLD : S_W_EN;
      S_W_EN:  return S_HOLD;
      default: return S_IDLE;
    endcase
  endfunction

  assign accept_start = (state_q == S_IDLE) && i_start && !i_stop;
  assign stop_now     = i_stop || stop_pend_q;
  assign is_write     = (state_q == S_W_RST) || (state_q == S_W_DIV) ||
                        (state_q == S_W_PER) || (state_q == S_W_DC)  ||
                        (state_q == S_W_EN)  || (state_q == S_W_STOP);

  wb_single_write #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wr (
    .clk     (i_wb_clk),
    .rst_n   (i_wb_rst_n),
    .go      (wr_go),
    .adr_in  (wr_adr),
    .data_in (wr_data),
    .ack     (wb.ack),
    .cyc     (wb.cyc),
    .stb     (wb.stb),
    .we      (wb.we),
    .adr     (wb.adr),
    .data    (wb.data),
    .busy    (wr_busy),
    .done    (wr_done),
    .timeout (wr_timeout)
  );

  always_comb begin
    wr_adr  = ADR_CTRL;
    wr_data = CTRL_OFF;
    case (state_q)
      S_W_RST: begin wr_adr = ADR_CTRL; wr_data = CTRL_RESET; end
      S_W_DIV: begin wr_adr = ADR_DIV;  wr_data = div_q;      end
      S_W_PER: begin wr_adr = ADR_PER;  wr_data = per_q;      end
      S_W_DC:  begin wr_adr = ADR_DC;   wr_data = dc_wr_q;    end
      S_W_EN:  begin wr_adr = ADR_CTRL; wr_data = CTRL_RUN;   end
      default: begin wr_adr = ADR_CTRL; wr_data = CTRL_OFF;   end
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_go   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_stop)       state_d = S_W_STOP;
        else if (i_start) state_d = S_W_RST;
      end
      S_HOLD: begin
        if (i_stop)
          state_d = S_W_STOP;
        else if (hold_cnt_q == hmax_q - 1'b1)
          state_d = ((dc_wr_q == end_q) || (step_q == '0)) ? S_FIN : S_W_DC;
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (is_write) begin
          // A launched write always runs to ack or timeout before a stop acts
          if (wr_timeout)
            state_d = S_IDLE;
          else if (wr_done)
            state_d = (stop_now && state_q != S_W_STOP) ? S_W_STOP
                                                        : seq_next(state_q, running_q);
          else if (!wr_busy) begin
            if (i_stop && state_q != S_W_STOP) state_d = S_W_STOP;
            else                               wr_go   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Control state
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q     <= S_IDLE;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      running_q   <= 1'b0;
      hold_cnt_q  <= '0;
      dc_cur_q    <= '0;
    end else begin
      state_q <= state_d;

      if (accept_start)    err_q <= 1'b0;
      else if (wr_timeout) err_q <= 1'b1;

      if (state_d != state_q)
        stop_pend_q <= 1'b0;
      else if (i_stop && wr_busy && !wr_done && !wr_timeout && state_q != S_W_STOP)
        stop_pend_q <= 1'b1;

      if (state_q == S_IDLE)                   running_q <= 1'b0;
      else if (state_q == S_W_EN && wr_done)   running_q <= 1'b1;

      hold_cnt_q <= (state_q == S_HOLD) ? hold_cnt_q + 1'b1 : '0;

      if (state_q == S_W_DC && wr_done) dc_cur_q <= dc_wr_q;
    end
  end

  // Latched configuration and the pending duty-cycle value
  always_ff @(posedge i_wb_clk) begin
    if (accept_start) begin
      div_q   <= i_divisor;
      per_q   <= i_period;
      end_q   <= i_dc_end;
      step_q  <= i_dc_step;
      hmax_q  <= (i_hold == '0) ? DATA_W'(1) : i_hold;
      up_q    <= (i_dc_end >= i_dc_start);
      dc_wr_q <= i_dc_start;
    end else if (state_q == S_HOLD && state_d == S_W_DC) begin
      dc_wr_q <= next_dc(dc_wr_q, step_q, end_q, up_q);
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_FIN);
  assign o_err    = err_q;
  assign o_dc_cur = dc_cur_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: table of ramp scenarios plus
// hand-written sequences for timeout, stop and reset corner cases.
module tb_pwm_ramp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start, stop;
  logic [15:0] divisor, period, dc_start, dc_end, dc_step, hold;
  logic        busy, done, err;
  logic [15:0] dc_cur;

  pwm_ramp_ctrl_if wb();

  pwm_ramp_ctrl #(.ACK_TIMEOUT(16)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_start    (start),
    .i_stop     (stop),
    .i_divisor  (divisor),
    .i_period   (period),
    .i_dc_start (dc_start),
    .i_dc_end   (dc_end),
    .i_dc_step  (dc_step),
    .i_hold     (hold),
    .wb         (wb.master),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_dc_cur   (dc_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: 0 = ack with stb, 1 = ack after 3 wait cycles, 2 = never
  int ack_mode = 0;
  int age = 0;
  always @(posedge clk) age <= (wb.stb && !wb.ack) ? age + 1 : 0;
  assign wb.ack = (ack_mode == 0) ? wb.stb :
                  (ack_mode == 1) ? (wb.stb && age >= 3) : 1'b0;

  // Bus monitor, sampled on the falling edge
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [31:0] wq[$];
  int          wt[$];
  logic        clr = 1'b0;
  int          done_cnt = 0, unstable = 0, bad_we = 0, b2b = 0;
  int          stb_total = 0, run = 0, max_run = 0;
  logic        stb_q = 1'b0, ack_q = 1'b0;
  logic [15:0] adr_q = '0, dat_q = '0;

  always @(negedge clk) begin
    if (clr) begin
      wq.delete();
      wt.delete();
      done_cnt <= 0; unstable <= 0; bad_we <= 0; b2b <= 0;
      stb_total <= 0; run <= 0; max_run <= 0;
    end else begin
      if (wb.stb) begin
        if (!wb.cyc || !wb.we) bad_we <= bad_we + 1;
        if (stb_q && !ack_q && (wb.adr != adr_q || wb.data != dat_q)) unstable <= unstable + 1;
        if (stb_q && ack_q) b2b <= b2b + 1;
        stb_total <= stb_total + 1;
        run <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
        if (wb.ack) begin
          wq.push_back({wb.adr, wb.data});
          wt.push_back(cyc_n);
        end
      end else begin
        run <= 0;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
    stb_q <= wb.stb;
    ack_q <= wb.ack;
    adr_q <= wb.adr;
    dat_q <= wb.data;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wq_at(input int k);
    if (k < wq.size()) return wq[k];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_mon();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic start_cfg(input logic [15:0] dv, pr, s, e, st, h);
    divisor = dv; period = pr; dc_start = s; dc_end = e; dc_step = st; hold = h;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [15:0]       dv, pr, s, e, st, h;
    int                ack;
    int                n;
    logic [0:9][31:0]  w;
    logic [15:0]       fin;
    int                gap;
  } scn_t;

  scn_t scn [7];

  task automatic run_scn(input int i);
    string nm;
    nm = $sformatf("scn%0d", i);
    ack_mode = scn[i].ack;
    clear_mon();
    start_cfg(scn[i].dv, scn[i].pr, scn[i].s, scn[i].e, scn[i].st, scn[i].h);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    wait_idle(nm, 2000);
    @(posedge clk); #1;
    chk({nm, "_nwr"}, 32'(wq.size()), 32'(scn[i].n));
    for (int k = 0; k < scn[i].n; k++)
      chk($sformatf("%s_wr%0d", nm, k), wq_at(k), scn[i].w[k]);
    chk({nm, "_done"}, 32'(done_cnt), 32'd1);
    chk({nm, "_dccur"}, {16'd0, dc_cur}, {16'd0, scn[i].fin});
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
    chk({nm, "_stable"}, 32'(unstable), 32'd0);
    chk({nm, "_we"}, 32'(bad_we), 32'd0);
    chk({nm, "_b2b"}, 32'(b2b), 32'd0);
    if (scn[i].gap != 0 && wt.size() >= 2)
      chk({nm, "_gap"}, 32'(wt[wt.size()-1] - wt[wt.size()-2]), 32'(scn[i].gap));
  endtask

  task automatic stop_only(input string nm, input logic with_start);
    ack_mode = 0;
    clear_mon();
    divisor = 16'd9; period = 16'd9; dc_start = 16'd1; dc_end = 16'd2; dc_step = 16'd1; hold = 16'd1;
    stop = 1'b1;
    start = with_start;
    @(posedge clk); #1;
    stop = 1'b0;
    start = 1'b0;
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    wait_idle(nm, 200);
    @(posedge clk); #1;
    chk({nm, "_nwr"}, 32'(wq.size()), 32'd1);
    chk({nm, "_wr0"}, wq_at(0), 32'h0000_0000);
    chk({nm, "_done"}, 32'(done_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Hold gap between ramp DC acks: write ack, hold cycles, one launch cycle
    scn[0] = '{16'd4, 16'd100, 16'd10, 16'd40, 16'd10, 16'd5, 0, 8,
               {32'h0000_0080, 32'h0002_0004, 32'h0004_0064, 32'h0006_000A, 32'h0000_0016,
                32'h0006_0014, 32'h0006_001E, 32'h0006_0028, 32'h0, 32'h0}, 16'd40, 7};
    scn[1] = '{16'd1, 16'd60, 16'd50, 16'd5, 16'd20, 16'd2, 0, 8,
               {32'h0000_0080, 32'h0002_0001, 32'h0004_003C, 32'h0006_0032, 32'h0000_0016,
                32'h0006_001E, 32'h0006_000A, 32'h0006_0005, 32'h0, 32'h0}, 16'd5, 4};
    scn[2] = scn[0];
    scn[2].ack = 1;
    scn[2].gap = 0;
    scn[3] = '{16'd2, 16'd10, 16'd7, 16'd7, 16'd3, 16'd0, 0, 5,
               {32'h0000_0080, 32'h0002_0002, 32'h0004_000A, 32'h0006_0007, 32'h0000_0016,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 16'd7, 0};
    scn[4] = '{16'd3, 16'd8, 16'd0, 16'd2, 16'd1, 16'd0, 0, 7,
               {32'h0000_0080, 32'h0002_0003, 32'h0004_0008, 32'h0006_0000, 32'h0000_0016,
                32'h0006_0001, 32'h0006_0002, 32'h0, 32'h0, 32'h0}, 16'd2, 3};
    scn[5] = '{16'd5, 16'hFFFF, 16'hFFF0, 16'hFFFF, 16'h0020, 16'd1, 0, 6,
               {32'h0000_0080, 32'h0002_0005, 32'h0004_FFFF, 32'h0006_FFF0, 32'h0000_0016,
                32'h0006_FFFF, 32'h0, 32'h0, 32'h0, 32'h0}, 16'hFFFF, 0};
    scn[6] = '{16'd6, 16'd50, 16'd10, 16'd40, 16'd0, 16'd3, 0, 5,
               {32'h0000_0080, 32'h0002_0006, 32'h0004_0032, 32'h0006_000A, 32'h0000_0016,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 16'd10, 0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    divisor = '0; period = '0; dc_start = '0; dc_end = '0; dc_step = '0; hold = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dccur", {16'd0, dc_cur}, 32'd0);
    chk("rst_cyc", {31'd0, wb.cyc}, 32'd0);
    chk("rst_stb", {31'd0, wb.stb}, 32'd0);
    chk("rst_we", {31'd0, wb.we}, 32'd0);
    chk("rst_adr", {16'd0, wb.adr}, 32'd0);
    chk("rst_data", {16'd0, wb.data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_scn(i);

    // Ack never returned
    ack_mode = 2;
    clear_mon();
    start_cfg(16'd4, 16'd100, 16'd10, 16'd40, 16'd10, 16'd5);
    wait_idle("tmo", 200);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_run", 32'(max_run), 32'd16);
    repeat (20) @(posedge clk);
    #1;
    chk("tmo_stb_total", 32'(stb_total), 32'd16);
    chk("tmo_nwr", 32'(wq.size()), 32'd0);
    chk("tmo_busy", {31'd0, busy}, 32'd0);

    // Stop during HOLD at dc=20; the start also clears the sticky error
    ack_mode = 0;
    clear_mon();
    start_cfg(16'd4, 16'd100, 16'd10, 16'd40, 16'd10, 16'd5);
    chk("hstop_err_clr", {31'd0, err}, 32'd0);
    n = 0;
    while (dc_cur != 16'd20 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hstop_reach20", {16'd0, dc_cur}, 32'd20);
    chk("hstop_first_wr", wq_at(0), 32'h0000_0080);
    clear_mon();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_idle("hstop", 200);
    @(posedge clk); #1;
    chk("hstop_nwr", 32'(wq.size()), 32'd1);
    chk("hstop_wr0", wq_at(0), 32'h0000_0000);
    chk("hstop_done", 32'(done_cnt), 32'd0);
    chk("hstop_dccur", {16'd0, dc_cur}, 32'd20);

    stop_only("istop", 1'b0);
    stop_only("startstop", 1'b1);

    // Asynchronous reset while the period write is on the bus
    ack_mode = 1;
    clear_mon();
    start_cfg(16'd4, 16'd100, 16'd10, 16'd40, 16'd10, 16'd5);
    n = 0;
    while (!(wb.stb && wb.adr == 16'd4) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("arst_in_wper", {31'd0, wb.stb}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", {31'd0, wb.cyc}, 32'd0);
    chk("arst_stb", {31'd0, wb.stb}, 32'd0);
    chk("arst_adr", {16'd0, wb.adr}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_dccur", {16'd0, dc_cur}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_scn(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
